// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared definitions for the parametrised data memory:
//   - default parameter constants (width, depth, address width)
//   - FSM state enum (INIT / IDLE)
//   - init_word(): value written to word idx by the initialisation pass
package dmem_pkg;

  localparam int DMEM_DEF_DATA_W = 8;
  localparam int DMEM_DEF_DEPTH  = 32;
  localparam int DMEM_DEF_ADDR_W = 8;

  typedef enum logic {
    INIT,
    IDLE
  } dmem_state_e;

  // Lower half of the array holds its own index, upper half counts down
  // from 0 in two's complement (0, -1, -2, ...). The signed difference is
  // sign-extended to 64 bits and masked to data_w, which yields the same
  // low bits as a narrow signed computation followed by truncation.
  function automatic logic [63:0] init_word(input int idx, input int depth,
                                            input int data_w);
    int          v;
    logic [63:0] w;
    logic [63:0] mask;
    if (idx < depth / 2) v = idx;
    else                 v = depth / 2 - idx;
    w    = {{32{v[31]}}, v};
    mask = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
    return w & mask;
  endfunction

endpackage

// File: rtl/dmem_init_seq.sv
// dmem_init_seq
//   Index counter and pattern generator for the initialisation pass.
//   Ports:
//     clk_i     clock
//     rst_ni    asynchronous active-low reset (counter back to 0)
//     active_i  high while the memory FSM is in INIT
//     we_o      write enable for the array during INIT
//     idx_o     word index being written this cycle
//     data_o    pattern value for idx_o
//     done_o    high in the cycle that writes the last word
module dmem_init_seq
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DEF_DATA_W,
  parameter int DEPTH  = DMEM_DEF_DEPTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       active_i,
  output logic                       we_o,
  output logic [$clog2(DEPTH)-1:0]   idx_o,
  output logic [DATA_W-1:0]          data_o,
  output logic                       done_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W-1:0] idx_q, idx_d;

  assign done_o = active_i && (idx_q == IDX_W'(DEPTH - 1));
  assign we_o   = active_i;
  assign idx_o  = idx_q;
  assign data_o = DATA_W'(init_word(int'(idx_q), DEPTH, DATA_W));

  // Counter parks at 0 outside INIT so a restarted pass always begins at word 0.
  always_comb begin
    idx_d = idx_q;
    if (!active_i || done_o) idx_d = '0;
    else                     idx_d = idx_q + IDX_W'(1);
  end

  // Index register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) idx_q <= '0;
    else         idx_q <= idx_d;
  end

endmodule

// File: rtl/param_data_memory.sv
// param_data_memory
//   Parametrised synchronous data memory with a power-up/re-init pass that
//   loads a fixed pattern, registered read data with a valid strobe, and
//   out-of-range address detection.
//   Ports:
//     clk           clock, rising edge
//     RST           asynchronous active-low reset
//     memAddress    word address for read/write
//     memWriteData  write data
//     MemRead       read request
//     MemWrite      write request
//     InitReq       restart the initialisation pass (IDLE only, has priority)
//     memReadData   registered read data (holds between reads)
//     memReadValid  one-cycle strobe: memReadData updated
//     memBusy       high while the init pass runs; requests ignored
//     memAddrErr    one-cycle strobe: previous access was out of range
//   Configuration macro: DMEM_WR_FORWARD_EN (same-cycle read+write returns
//   memWriteData instead of the old contents).
module param_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DEF_DATA_W,
  parameter int DEPTH  = DMEM_DEF_DEPTH,
  parameter int ADDR_W = DMEM_DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [ADDR_W-1:0] memAddress,
  input  logic [DATA_W-1:0] memWriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              InitReq,
  output logic [DATA_W-1:0] memReadData,
  output logic              memReadValid,
  output logic              memBusy,
  output logic              memAddrErr
);

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_e       state_q;
  logic [DATA_W-1:0] memReadData_q;
  logic              memReadValid_q;
  logic              memBusy_q;
  logic              memAddrErr_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              initWe;
  logic [IDX_W-1:0]  initIdx;
  logic [DATA_W-1:0] initData;
  logic              initDone;

  logic              inRange;
  logic [IDX_W-1:0]  memIdx;
  logic              accessOk;
  logic              rdFire;
  logic              accErr;
  logic              wrEn;
  logic [IDX_W-1:0]  wrIdx;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] rdData_d;

  dmem_init_seq #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_initSeq (
    .clk_i    (clk),
    .rst_ni   (RST),
    .active_i (state_q == INIT),
    .we_o     (initWe),
    .idx_o    (initIdx),
    .data_o   (initData),
    .done_o   (initDone)
  );

  // Compare the full address one bit wider than ADDR_W so DEPTH == 2^ADDR_W works.
  assign inRange  = {1'b0, memAddress} < (ADDR_W + 1)'(DEPTH);
  assign memIdx   = memAddress[IDX_W-1:0];
  assign accessOk = (state_q == IDLE) && !InitReq;
  assign rdFire   = accessOk && MemRead;
  assign accErr   = accessOk && (MemRead || MemWrite) && !inRange;

  // Array write port: the init sequencer owns it in INIT, the datapath in IDLE.
  always_comb begin
    wrEn   = 1'b0;
    wrIdx  = initIdx;
    wrData = initData;
    if (state_q == INIT) begin
      wrEn = initWe;
    end else if (accessOk && MemWrite && inRange) begin
      wrEn   = 1'b1;
      wrIdx  = memIdx;
      wrData = memWriteData;
    end
  end

  // Read data selection; out-of-range reads return zero.
  always_comb begin
    rdData_d = '0;
    if (inRange) begin
`ifdef DMEM_WR_FORWARD_EN
      if (MemWrite) rdData_d = memWriteData;
      else          rdData_d = mem_q[memIdx];
`else
      rdData_d = mem_q[memIdx];
`endif
    end
  end

  // Storage is deliberately not reset; only the init pass defines contents.
  always_ff @(posedge clk) begin
    if (wrEn) mem_q[wrIdx] <= wrData;
  end

  // FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q        <= INIT;
      memReadData_q  <= '0;
      memReadValid_q <= 1'b0;
      memAddrErr_q   <= 1'b0;
      memBusy_q      <= 1'b1;
    end else begin
      memReadValid_q <= 1'b0;
      memAddrErr_q   <= 1'b0;
      case (state_q)
        INIT: begin
          if (initDone) begin
            state_q   <= IDLE;
            memBusy_q <= 1'b0;
          end
        end
        IDLE: begin
          if (InitReq) begin
            state_q   <= INIT;
            memBusy_q <= 1'b1;
          end else begin
            memReadValid_q <= rdFire;
            memAddrErr_q   <= accErr;
            if (rdFire) memReadData_q <= rdData_d;
          end
        end
        default: begin
          state_q   <= INIT;
          memBusy_q <= 1'b1;
        end
      endcase
    end
  end

  assign memReadData  = memReadData_q;
  assign memReadValid = memReadValid_q;
  assign memBusy      = memBusy_q;
  assign memAddrErr   = memAddrErr_q;

endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory
//   Self-checking bench for param_data_memory with default parameters.
//   A transaction-level model predicts the outputs; they are compared on
//   every falling edge, alongside hand-computed literal expectations.
module tb_param_data_memory;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 8;

`ifdef DMEM_WR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RST = 1'b1;
  logic [ADDR_W-1:0] memAddress = '0;
  logic [DATA_W-1:0] memWriteData = '0;
  logic              MemRead = 1'b0;
  logic              MemWrite = 1'b0;
  logic              InitReq = 1'b0;
  logic [DATA_W-1:0] memReadData;
  logic              memReadValid;
  logic              memBusy;
  logic              memAddrErr;

  int nChecks = 0;
  int nErrors = 0;

  param_data_memory #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk          (clk),
    .RST          (RST),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .InitReq      (InitReq),
    .memReadData  (memReadData),
    .memReadValid (memReadValid),
    .memBusy      (memBusy),
    .memAddrErr   (memAddrErr)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of requests; returns just after the rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic ini,
                               input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] wdata);
    MemRead      = rd;
    MemWrite     = wr;
    InitReq      = ini;
    memAddress   = addr;
    memWriteData = wdata;
    @(posedge clk);
    #1;
  endtask

  // Expected contents after an init pass: index in the lower half, then
  // 0, -1, -2, ... modulo 2^DATA_W in the upper half.
  function automatic int patternWord(input int i);
    int m;
    m = 1 << DATA_W;
    if (i < DEPTH / 2) return i;
    return ((DEPTH / 2 - i) % m + m) % m;
  endfunction

  // Behavioural model: memory as an int array, init pass as a countdown.
  int                modelMem [DEPTH];
  logic [DATA_W-1:0] expData  = '0;
  logic              expValid = 1'b0;
  logic              expErr   = 1'b0;
  logic              expBusy  = 1'b1;
  int                initLeft = DEPTH;
  logic              addrOk;

  assign addrOk = int'(memAddress) < DEPTH;

  always @(posedge clk or negedge RST) begin
    if (!RST) begin
      expData  <= '0;
      expValid <= 1'b0;
      expErr   <= 1'b0;
      expBusy  <= 1'b1;
      initLeft <= DEPTH;
    end else if (expBusy) begin
      expValid <= 1'b0;
      expErr   <= 1'b0;
      if (initLeft == 1) begin
        expBusy <= 1'b0;
        for (int i = 0; i < DEPTH; i++) modelMem[i] <= patternWord(i);
      end
      initLeft <= initLeft - 1;
    end else if (InitReq) begin
      expBusy  <= 1'b1;
      initLeft <= DEPTH;
      expValid <= 1'b0;
      expErr   <= 1'b0;
    end else begin
      expValid <= MemRead;
      expErr   <= (MemRead || MemWrite) && !addrOk;
      if (MemRead) begin
        if (!addrOk)             expData <= '0;
        else if (FWD && MemWrite) expData <= memWriteData;
        else                      expData <= DATA_W'(modelMem[memAddress]);
      end
      if (MemWrite && addrOk) modelMem[memAddress] <= int'(memWriteData);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("cmpReadData", 32'(memReadData), 32'(expData));
    checkOutput("cmpReadValid", 32'(memReadValid), 32'(expValid));
    checkOutput("cmpAddrErr", 32'(memAddrErr), 32'(expErr));
    checkOutput("cmpBusy", 32'(memBusy), 32'(expBusy));
  end

  // Idle until memBusy drops, bounded; returns number of cycles waited.
  task automatic waitBusyLow(output int n);
    n = 0;
    while (memBusy && n < 64) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      n++;
    end
    checkOutput("busyTimeout", 32'(memBusy), 32'd0);
  endtask

  initial begin
    int n;
    logic [ADDR_W-1:0] ra;

    #1 RST = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstData", 32'(memReadData), 32'h0);
    checkOutput("rstValid", 32'(memReadValid), 32'h0);
    checkOutput("rstErr", 32'(memAddrErr), 32'h0);
    checkOutput("rstBusy", 32'(memBusy), 32'h1);
    RST = 1'b1;

    // Init pass with reads requested throughout: no valid, busy for 32 cycles.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, ADDR_W'(i), '0);
      checkOutput("initNoValid", 32'(memReadValid), 32'h0);
      checkOutput("initBusy", 32'(memBusy), (i < DEPTH - 1) ? 32'h1 : 32'h0);
    end

    applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, '0);
    checkOutput("rd5", 32'(memReadData), 32'h05);
    checkOutput("rd5Valid", 32'(memReadValid), 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd16, '0);
    checkOutput("rd16", 32'(memReadData), 32'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd17, '0);
    checkOutput("rd17", 32'(memReadData), 32'hFF);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd31, '0);
    checkOutput("rd31", 32'(memReadData), 32'hF1);
    checkOutput("backToBackValid", 32'(memReadValid), 32'h1);

    // Write then read next cycle; valid for exactly one cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd3, 8'hA5);
    checkOutput("wrNoValid", 32'(memReadValid), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd3, '0);
    checkOutput("rd3", 32'(memReadData), 32'hA5);
    checkOutput("rd3Valid", 32'(memReadValid), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("rd3ValidDrop", 32'(memReadValid), 32'h0);
    checkOutput("rd3Hold", 32'(memReadData), 32'hA5);

    // Same-cycle read and write.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd7, 8'h3C);
    checkOutput("rwSame", 32'(memReadData), FWD ? 32'h3C : 32'h07);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd7, '0);
    checkOutput("rwFollow", 32'(memReadData), 32'h3C);

    // Out-of-range accesses.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd40, '0);
    checkOutput("oorRdData", 32'(memReadData), 32'h0);
    checkOutput("oorRdValid", 32'(memReadValid), 32'h1);
    checkOutput("oorRdErr", 32'(memAddrErr), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd200, 8'h55);
    checkOutput("oorWrErr", 32'(memAddrErr), 32'h1);
    checkOutput("oorWrValid", 32'(memReadValid), 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd40, 8'h66);
    checkOutput("oorRwErr", 32'(memAddrErr), 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("oorErrDrop", 32'(memAddrErr), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, ADDR_W'(i), '0);
      checkOutput("scan", 32'(memReadData),
                  (i == 3) ? 32'hA5 : (i == 7) ? 32'h3C : 32'(patternWord(i)));
    end

    // Randomised traffic, mostly in range, with occasional re-init.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) ra = ADDR_W'($urandom_range(DEPTH, 255));
      else                           ra = ADDR_W'($urandom_range(0, DEPTH - 1));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 63) == 0), ra, DATA_W'($urandom));
    end
    waitBusyLow(n);

    // InitReq wins over a same-cycle write.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd2, 8'h11);
    checkOutput("initReqBusy", 32'(memBusy), 32'h1);
    waitBusyLow(n);
    checkOutput("initReqLen", 32'(n), 32'(DEPTH));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd2, '0);
    checkOutput("rd2AfterInit", 32'(memReadData), 32'h02);

    // Reset in the middle of an init pass.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd5, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, '0, '0);
    repeat (10) applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    #2 RST = 1'b0;
    #1;
    checkOutput("midRstData", 32'(memReadData), 32'h0);
    checkOutput("midRstValid", 32'(memReadValid), 32'h0);
    checkOutput("midRstErr", 32'(memAddrErr), 32'h0);
    checkOutput("midRstBusy", 32'(memBusy), 32'h1);
    @(negedge clk);
    RST = 1'b1;
    waitBusyLow(n);
    checkOutput("midRstInitLen", 32'(n), 32'(DEPTH));
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd10, '0);
    checkOutput("rd10AfterRst", 32'(memReadData), 32'h0A);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
